// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite bus constants, slave FSM states and byte-lane helper.
package ahb3lite_pkg;

    localparam int HADDR_SIZE = 32;
    localparam int HDATA_SIZE = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DONE,
        ERR1,
        ERR2
    } ahb_slv_state_t;

    // Little-endian lane enables for an aligned transfer.
    function automatic logic [3:0] ahb_byte_en(
        input logic [2:0] size,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            (size == HSIZE_BYTE):  be = 4'b0001 << a;
            (size == HSIZE_HWORD): be = a[1] ? 4'b1100 : 4'b0011;
            default:               be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-wide storage with per-byte write enables.
// Synchronous write, combinational read, single shared address.
module ahb_slave_mem_array #(
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          HCLK,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_slave_mem.sv
// AHB3-Lite memory responder with programmable wait states,
// byte-lane writes and the two-cycle ERROR response.
module ahb3lite_slave_mem #(
    parameter int HADDR_SIZE  = ahb3lite_pkg::HADDR_SIZE,
    parameter int HDATA_SIZE  = ahb3lite_pkg::HDATA_SIZE,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    import ahb3lite_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH) + 2;
    localparam logic [HADDR_SIZE-1:0] LIMIT = HADDR_SIZE'(MEM_DEPTH * 4);

    ahb_slv_state_t        state;
    logic [3:0]            wcnt;
    logic [AW-1:0]         lat_addr;
    logic                  lat_write;
    logic [2:0]            lat_size;
    logic [HDATA_SIZE-1:0] rd_hold;
    logic [HDATA_SIZE-1:0] mem_rdata;
    logic                  accept;
    logic                  bad;
    logic                  mem_we;
    logic [3:0]            be;
    logic                  unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    assign accept = HSEL && HREADY &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    assign bad = (HSIZE > HSIZE_WORD) ||
                 (HADDR >= LIMIT) ||
                 (HSIZE == HSIZE_HWORD && HADDR[0]) ||
                 (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

    assign be = ahb_byte_en(lat_size, lat_addr[1:0]);

    // Reset on the commit edge drops the pending write.
    assign mem_we = (state == DONE) && lat_write && !HRESET;

    // Read data comes straight from the array in DONE so a write
    // committed on the previous edge is already visible.
    assign HRDATA = (state == DONE && !lat_write) ? mem_rdata : rd_hold;

    ahb_slave_mem_array #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_array (
        .HCLK  (HCLK),
        .we    (mem_we),
        .be    (be),
        .addr  (lat_addr[AW-1:2]),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            wcnt      <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            rd_hold   <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            if (state == DONE && !lat_write) begin
                rd_hold <= mem_rdata;
            end
            unique case (state)
                IDLE, DONE, ERR2: begin
                    if (accept) begin
                        lat_addr  <= HADDR[AW-1:0];
                        lat_write <= HWRITE;
                        lat_size  <= HSIZE;
                        if (bad) begin
                            state     <= ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state     <= WAIT;
                            wcnt      <= 4'(WAIT_STATES - 1);
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
                        end else begin
                            state     <= DONE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) begin
                        state     <= DONE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_slave_mem.sv
// Bench for ahb3lite_slave_mem: a zero-wait and a two-wait instance
// share one bus; a scoreboard queue holds expected completions.
module tb_ahb3lite_slave_mem;

    import ahb3lite_pkg::*;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        int          waits;
        logic [31:0] rdata;
        logic        chk;
    } vec_t;

    typedef struct {
        logic        err;
        int          waits;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        sel;

    logic [31:0] rd0, rd2;
    logic        ro0, ro2, rs0, rs2;
    logic        cur_ro, cur_rs;
    logic [31:0] cur_rd;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[20];

    assign HREADY = sel ? ro2 : ro0;
    assign cur_ro = sel ? ro2 : ro0;
    assign cur_rs = sel ? rs2 : rs0;
    assign cur_rd = sel ? rd2 : rd0;

    ahb3lite_slave_mem #(
        .MEM_DEPTH(256),
        .WAIT_STATES(0)
    ) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL && !sel),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb3lite_slave_mem #(
        .MEM_DEPTH(256),
        .WAIT_STATES(2)
    ) u2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL && sel),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic sel_i, input logic wr, input logic [31:0] addr,
        input logic [2:0] size, input logic [31:0] wdata,
        input logic err, input int waits, input logic [31:0] rdata,
        input logic c
    );
        vec_t v;
        v.sel = sel_i; v.wr = wr; v.addr = addr; v.size = size;
        v.wdata = wdata; v.err = err; v.waits = waits;
        v.rdata = rdata; v.chk = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic wr, input logic [31:0] addr,
                              input logic [2:0] size);
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
    endtask

    task automatic push(input logic err, input int waits,
                        input logic [31:0] rdata, input logic c);
        exp_t e;
        e.err = err; e.waits = waits; e.rdata = rdata; e.chk = c;
        sb.push_back(e);
    endtask

    // Follow a data phase to completion, then compare with the queue head.
    task automatic complete(input string nm);
        exp_t e;
        int   w;
        int   n;
        logic done_f;
        logic err_f;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        w = 0;
        n = 0;
        done_f = 1'b0;
        err_f = 1'b0;
        while (!done_f && n < 20) begin
            if (cur_ro) begin
                done_f = 1'b1;
            end else begin
                if (cur_rs) err_f = 1'b1;
                else w++;
                tick();
            end
            n++;
        end
        chk({nm, " ready"}, 32'(done_f), 32'd1);
        chk({nm, " waits"}, 32'(w), 32'(e.waits));
        chk({nm, " resp"}, {30'd0, err_f, cur_rs}, {30'd0, e.err, e.err});
        if (e.chk) chk({nm, " rdata"}, cur_rd, e.rdata);
    endtask

    task automatic do_xfer(input vec_t v, input string nm);
        sel = v.sel;
        drive_addr(v.wr, v.addr, v.size);
        push(v.err, v.waits, v.rdata, v.chk);
        tick();
        HTRANS = HTRANS_IDLE;
        HWDATA = v.wdata;
        complete(nm);
        tick();
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 32'h010, 2, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h010, 2, 32'h0, 0, 0, 32'hDEADBEEF, 1);
        tbl[2]  = mk(1, 1, 32'h000, 2, 32'h01234567, 0, 2, 0, 0);
        tbl[3]  = mk(1, 0, 32'h000, 2, 32'h0, 0, 2, 32'h01234567, 1);
        tbl[4]  = mk(0, 1, 32'h020, 2, 32'h11223344, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 32'h021, 0, 32'hFFFFAAFF, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 32'h020, 2, 32'h0, 0, 0, 32'h1122AA44, 1);
        tbl[7]  = mk(0, 0, 32'h400, 2, 32'h0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 32'h003, 1, 32'h0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 1, 32'h020, 3, 32'h0, 1, 0, 0, 0);
        tbl[10] = mk(0, 1, 32'h022, 2, 32'h0, 1, 0, 0, 0);
        tbl[11] = mk(0, 1, 32'h400, 0, 32'h0, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 32'h020, 2, 32'h0, 0, 0, 32'h1122AA44, 1);
        tbl[13] = mk(0, 1, 32'h022, 1, 32'hBEEF0000, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 32'h020, 2, 32'h0, 0, 0, 32'hBEEFAA44, 1);
        tbl[15] = mk(0, 1, 32'h023, 0, 32'h77000000, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 32'h020, 2, 32'h0, 0, 0, 32'h77EFAA44, 1);
        tbl[17] = mk(1, 1, 32'h3FC, 2, 32'h0BADF00D, 0, 2, 0, 0);
        tbl[18] = mk(1, 0, 32'h3FC, 2, 32'h0, 0, 2, 32'h0BADF00D, 1);
        tbl[19] = mk(1, 1, 32'h030, 2, 32'h12345678, 0, 2, 0, 0);

        sel = 1'b0;
        HRESET = 1'b1;
        HSEL = 1'b0;
        HADDR = '0;
        HWRITE = 1'b0;
        HSIZE = HSIZE_WORD;
        HBURST = '0;
        HPROT = '0;
        HTRANS = HTRANS_IDLE;
        HMASTLOCK = 1'b0;
        HWDATA = '0;
        repeat (2) tick();

        chk("rst ready0", 32'(ro0), 32'd1);
        chk("rst resp0", 32'(rs0), 32'd0);
        chk("rst rdata0", rd0, 32'd0);
        chk("rst ready2", 32'(ro2), 32'd1);
        chk("rst resp2", 32'(rs2), 32'd0);
        chk("rst rdata2", rd2, 32'd0);
        HRESET = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            do_xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset during a wait state drops the write to 0x30.
        sel = 1'b1;
        drive_addr(1'b1, 32'h030, HSIZE_WORD);
        tick();
        HTRANS = HTRANS_IDLE;
        HWDATA = 32'h5555AAAA;
        chk("midrst wait", 32'(ro2), 32'd0);
        HRESET = 1'b1;
        tick();
        chk("midrst ready", 32'(ro2), 32'd1);
        chk("midrst resp", 32'(rs2), 32'd0);
        chk("midrst rdata", rd2, 32'd0);
        HRESET = 1'b0;
        tick();
        do_xfer(mk(1, 0, 32'h030, 2, 32'h0, 0, 2, 32'h12345678, 1),
                "midrst r30");

        // BUSY and IDLE with HSEL: zero-wait OKAY, no write.
        sel = 1'b0;
        HSEL = 1'b1;
        HWRITE = 1'b1;
        HADDR = 32'h010;
        HSIZE = HSIZE_WORD;
        HTRANS = HTRANS_BUSY;
        tick();
        HWDATA = 32'hFFFFFFFF;
        chk("busy ready", 32'(ro0), 32'd1);
        chk("busy resp", 32'(rs0), 32'd0);
        HTRANS = HTRANS_IDLE;
        tick();
        chk("idle ready", 32'(ro0), 32'd1);
        chk("idle resp", 32'(rs0), 32'd0);
        tick();
        do_xfer(mk(0, 0, 32'h010, 2, 32'h0, 0, 0, 32'hDEADBEEF, 1),
                "busy r10");

        // Pipelined write then read of the same word.
        sel = 1'b0;
        drive_addr(1'b1, 32'h040, HSIZE_WORD);
        push(1'b0, 0, 32'h0, 1'b0);
        tick();
        drive_addr(1'b0, 32'h040, HSIZE_WORD);
        HWDATA = 32'hCAFEF00D;
        push(1'b0, 0, 32'hCAFEF00D, 1'b1);
        complete("b2b wr");
        tick();
        HTRANS = HTRANS_IDLE;
        HWDATA = '0;
        complete("b2b rd");
        tick();
        chk("b2b hold", rd0, 32'hCAFEF00D);
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
